qix_shared_mailbox: RTL

QIX_SHARED_MAILBOX -- requirements
Module: qix_shared_mailbox

---
 rtl/qix_shared_mailbox.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/qix_shared_mailbox.sv
// Dual-port shared RAM plus a bidirectional mailbox (MSG/STATUS/DOORBELL) with FIRQ outputs.
// Optional macro QIX_MBOX_OVERFLOW_EN: drop MSG writes while full and flag sticky overflow.
module qix_shared_mailbox #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_20m,
    input  logic              reset_n,
    input  logic              a_cs,
    input  logic              a_we,
    input  logic [ADDR_W:0]   a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_firq,
    input  logic              b_cs,
    input  logic              b_we,
    input  logic [ADDR_W:0]   b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_firq
);

    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: cs is a one-cycle strobe with no back-pressure; every access
    // completes in its cs cycle and read data lands on dout on the next cycle.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] msg_ab, msg_ba, msg_ab_nxt, msg_ba_nxt;
    logic              full_ab, full_ba, full_ab_nxt, full_ba_nxt;
    logic              db_ab, db_ba, db_ab_nxt, db_ba_nxt;
    logic              ovf_ab, ovf_ba, ovf_ab_nxt, ovf_ba_nxt;

    logic a_ram, a_reg, b_ram, b_reg;
    logic a_msg_wr, a_msg_rd, a_stat_rd, a_db_wr, a_db_rd;
    logic b_msg_wr, b_msg_rd, b_stat_rd, b_db_wr, b_db_rd;
    logic [DATA_W-1:0] a_reg_rdata, b_reg_rdata;

    // Register window is only the four words at the bottom of the upper half.
    assign a_ram = a_cs && !a_addr[ADDR_W];
    assign b_ram = b_cs && !b_addr[ADDR_W];
    assign a_reg = a_cs && a_addr[ADDR_W] && (a_addr[ADDR_W-1:2] == '0);
    assign b_reg = b_cs && b_addr[ADDR_W] && (b_addr[ADDR_W-1:2] == '0);

    assign a_msg_wr  = a_reg &&  a_we && (a_addr[1:0] == 2'd0);
    assign a_msg_rd  = a_reg && !a_we && (a_addr[1:0] == 2'd0);
    assign a_stat_rd = a_reg && !a_we && (a_addr[1:0] == 2'd1);
    assign a_db_wr   = a_reg &&  a_we && (a_addr[1:0] == 2'd2);
    assign a_db_rd   = a_reg && !a_we && (a_addr[1:0] == 2'd2);
    assign b_msg_wr  = b_reg &&  b_we && (b_addr[1:0] == 2'd0);
    assign b_msg_rd  = b_reg && !b_we && (b_addr[1:0] == 2'd0);
    assign b_stat_rd = b_reg && !b_we && (b_addr[1:0] == 2'd1);
    assign b_db_wr   = b_reg &&  b_we && (b_addr[1:0] == 2'd2);
    assign b_db_rd   = b_reg && !b_we && (b_addr[1:0] == 2'd2);

    always_comb begin
        msg_ab_nxt  = msg_ab;
        msg_ba_nxt  = msg_ba;
        full_ab_nxt = full_ab;
        full_ba_nxt = full_ba;
        db_ab_nxt   = db_ab;
        db_ba_nxt   = db_ba;
        ovf_ab_nxt  = 1'b0;
        ovf_ba_nxt  = 1'b0;

        // Clears come first so a coincident set wins.
        if (b_msg_rd) full_ab_nxt = 1'b0;
        if (a_msg_rd) full_ba_nxt = 1'b0;
        if (b_db_rd)  db_ab_nxt   = 1'b0;
        if (a_db_rd)  db_ba_nxt   = 1'b0;
        if (a_db_wr)  db_ab_nxt   = 1'b1;
        if (b_db_wr)  db_ba_nxt   = 1'b1;

`ifdef QIX_MBOX_OVERFLOW_EN
        ovf_ab_nxt = ovf_ab && !b_stat_rd;
        ovf_ba_nxt = ovf_ba && !a_stat_rd;
        if (a_msg_wr) begin
            if (full_ab && !b_msg_rd) begin
                ovf_ab_nxt = 1'b1;
            end else begin
                msg_ab_nxt  = a_din;
                full_ab_nxt = 1'b1;
            end
        end
        if (b_msg_wr) begin
            if (full_ba && !a_msg_rd) begin
                ovf_ba_nxt = 1'b1;
            end else begin
                msg_ba_nxt  = b_din;
                full_ba_nxt = 1'b1;
            end
        end
`else
        if (a_msg_wr) begin
            msg_ab_nxt  = a_din;
            full_ab_nxt = 1'b1;
        end
        if (b_msg_wr) begin
            msg_ba_nxt  = b_din;
            full_ba_nxt = 1'b1;
        end
`endif
    end

    // Register-window read data; "in" is the direction towards the reader.
    always_comb begin
        a_reg_rdata = '0;
        b_reg_rdata = '0;
        if (a_reg) begin
            case (a_addr[1:0])
                2'd0:    a_reg_rdata = msg_ba;
                2'd1:    a_reg_rdata[2:0] = {ovf_ba, full_ab, full_ba};
                2'd2:    a_reg_rdata[0] = db_ba;
                default: a_reg_rdata = '0;
            endcase
        end
        if (b_reg) begin
            case (b_addr[1:0])
                2'd0:    b_reg_rdata = msg_ab;
                2'd1:    b_reg_rdata[2:0] = {ovf_ab, full_ba, full_ab};
                2'd2:    b_reg_rdata[0] = db_ab;
                default: b_reg_rdata = '0;
            endcase
        end
    end

    // RAM is not reset; port A's write is issued last so it wins a collision.
    always_ff @(posedge clk_20m) begin
        if (reset_n && b_ram && b_we) mem[b_addr[ADDR_W-1:0]] <= b_din;
        if (reset_n && a_ram && a_we) mem[a_addr[ADDR_W-1:0]] <= a_din;
    end

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            msg_ab  <= '0;
            msg_ba  <= '0;
            full_ab <= 1'b0;
            full_ba <= 1'b0;
            db_ab   <= 1'b0;
            db_ba   <= 1'b0;
            ovf_ab  <= 1'b0;
            ovf_ba  <= 1'b0;
            a_firq  <= 1'b0;
            b_firq  <= 1'b0;
            a_dout  <= '0;
            b_dout  <= '0;
        end else begin
            msg_ab  <= msg_ab_nxt;
            msg_ba  <= msg_ba_nxt;
            full_ab <= full_ab_nxt;
            full_ba <= full_ba_nxt;
            db_ab   <= db_ab_nxt;
            db_ba   <= db_ba_nxt;
            ovf_ab  <= ovf_ab_nxt;
            ovf_ba  <= ovf_ba_nxt;
            a_firq  <= full_ba_nxt | db_ba_nxt;
            b_firq  <= full_ab_nxt | db_ab_nxt;
            if (a_cs && !a_we) a_dout <= a_ram ? mem[a_addr[ADDR_W-1:0]] : a_reg_rdata;
            if (b_cs && !b_we) b_dout <= b_ram ? mem[b_addr[ADDR_W-1:0]] : b_reg_rdata;
        end
    end

endmodule
